// File: rtl/gold_ring_noc.sv
`default_nettype none
// ============================================================================
// Module   : gold_ring_noc
// Brief    : Four-node bidirectional source-routed ring NoC, two phased VCs.
// Revision : 1.0
// ============================================================================
module gold_ring_noc (
  input  logic        clk,
  input  logic        reset,
  output logic        polarity,
  input  logic        pesi_node0,
  output logic        peri_node0,
  input  logic [63:0] pedi_node0,
  output logic        peso_node0,
  input  logic        pero_node0,
  output logic [63:0] pedo_node0,
  input  logic        pesi_node1,
  output logic        peri_node1,
  input  logic [63:0] pedi_node1,
  output logic        peso_node1,
  input  logic        pero_node1,
  output logic [63:0] pedo_node1,
  input  logic        pesi_node2,
  output logic        peri_node2,
  input  logic [63:0] pedi_node2,
  output logic        peso_node2,
  input  logic        pero_node2,
  output logic [63:0] pedo_node2,
  input  logic        pesi_node3,
  output logic        peri_node3,
  input  logic [63:0] pedi_node3,
  output logic        peso_node3,
  input  logic        pero_node3,
  output logic [63:0] pedo_node3
);

  localparam int         c_NODES   = 4;
  localparam logic [1:0] c_TGT_PE  = 2'd0;
  localparam logic [1:0] c_TGT_CW  = 2'd1;
  localparam logic [1:0] c_TGT_CCW = 2'd2;

  logic        r_pol;
  logic [1:0]  r_cwin_v   [c_NODES];
  logic [1:0]  r_ccwin_v  [c_NODES];
  logic [1:0]  r_cwout_v  [c_NODES];
  logic [1:0]  r_ccwout_v [c_NODES];
  logic [63:0] r_cwin_d   [c_NODES][2];
  logic [63:0] r_ccwin_d  [c_NODES][2];
  logic [63:0] r_cwout_d  [c_NODES][2];
  logic [63:0] r_ccwout_d [c_NODES][2];
  logic        r_pein_v   [c_NODES];
  logic [63:0] r_pein_d   [c_NODES];
  logic        r_peout_v  [c_NODES];
  logic [63:0] r_peout_d  [c_NODES];

  logic [1:0]  w_n_cwin_v   [c_NODES];
  logic [1:0]  w_n_ccwin_v  [c_NODES];
  logic [1:0]  w_n_cwout_v  [c_NODES];
  logic [1:0]  w_n_ccwout_v [c_NODES];
  logic [63:0] w_n_cwin_d   [c_NODES][2];
  logic [63:0] w_n_ccwin_d  [c_NODES][2];
  logic [63:0] w_n_cwout_d  [c_NODES][2];
  logic [63:0] w_n_ccwout_d [c_NODES][2];
  logic        w_n_pein_v   [c_NODES];
  logic [63:0] w_n_pein_d   [c_NODES];
  logic        w_n_peout_v  [c_NODES];
  logic [63:0] w_n_peout_d  [c_NODES];

  logic        w_pesi [c_NODES];
  logic        w_pero [c_NODES];
  logic [63:0] w_pedi [c_NODES];

  // Internal-phase sources per node: 0 = cw_in, 1 = ccw_in, 2 = pe_in.
  logic        w_q;
  logic [2:0]  w_src_v [c_NODES];
  logic [63:0] w_src_d [c_NODES][3];
  logic [2:0]  w_free  [c_NODES];
  logic [2:0]  w_taken [c_NODES];
  logic [2:0]  w_gnt   [c_NODES];
  logic [1:0]  w_tgt   [c_NODES][3];

  assign w_pesi[0] = pesi_node0;
  assign w_pesi[1] = pesi_node1;
  assign w_pesi[2] = pesi_node2;
  assign w_pesi[3] = pesi_node3;
  assign w_pero[0] = pero_node0;
  assign w_pero[1] = pero_node1;
  assign w_pero[2] = pero_node2;
  assign w_pero[3] = pero_node3;
  assign w_pedi[0] = pedi_node0;
  assign w_pedi[1] = pedi_node1;
  assign w_pedi[2] = pedi_node2;
  assign w_pedi[3] = pedi_node3;

  assign polarity   = r_pol;
  assign peri_node0 = ~r_pein_v[0];
  assign peri_node1 = ~r_pein_v[1];
  assign peri_node2 = ~r_pein_v[2];
  assign peri_node3 = ~r_pein_v[3];
  assign peso_node0 = r_peout_v[0];
  assign peso_node1 = r_peout_v[1];
  assign peso_node2 = r_peout_v[2];
  assign peso_node3 = r_peout_v[3];
  assign pedo_node0 = r_peout_d[0];
  assign pedo_node1 = r_peout_d[1];
  assign pedo_node2 = r_peout_d[2];
  assign pedo_node3 = r_peout_d[3];

  assign w_q = ~r_pol;

  function automatic logic [1:0] f_route(input logic [63:0] pkt);
    if (pkt[55:48] == 8'h00) return c_TGT_PE;
    return pkt[62] ? c_TGT_CCW : c_TGT_CW;
  endfunction

  // Consumes one hop and stamps the packet with the VC of the slot it enters.
  function automatic logic [63:0] f_link(input logic [63:0] pkt, input logic vc);
    return {vc, pkt[62:56], 1'b0, pkt[55:49], pkt[47:0]};
  endfunction

  always_comb begin
    for (int n = 0; n < c_NODES; n++) begin
      w_src_v[n]    = {r_pein_v[n], r_ccwin_v[n][w_q], r_cwin_v[n][w_q]};
      w_src_d[n][0] = r_cwin_d[n][w_q];
      w_src_d[n][1] = r_ccwin_d[n][w_q];
      w_src_d[n][2] = r_pein_d[n];
      // pe_out counts as free when it is being drained this same cycle.
      w_free[n]     = {~r_ccwout_v[n][w_q], ~r_cwout_v[n][w_q], ~r_peout_v[n] | w_pero[n]};
    end
  end

  // Fixed priority per target: cw_in, then ccw_in, then pe_in.
  always_comb begin
    for (int n = 0; n < c_NODES; n++) begin
      w_taken[n] = 3'b000;
      w_gnt[n]   = 3'b000;
      for (int s = 0; s < 3; s++) begin
        w_tgt[n][s] = f_route(w_src_d[n][s]);
        if (w_src_v[n][s] && w_free[n][w_tgt[n][s]] && !w_taken[n][w_tgt[n][s]]) begin
          w_gnt[n][s]               = 1'b1;
          w_taken[n][w_tgt[n][s]]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_n_cwin_v   = r_cwin_v;
    w_n_ccwin_v  = r_ccwin_v;
    w_n_cwout_v  = r_cwout_v;
    w_n_ccwout_v = r_ccwout_v;
    w_n_cwin_d   = r_cwin_d;
    w_n_ccwin_d  = r_ccwin_d;
    w_n_cwout_d  = r_cwout_d;
    w_n_ccwout_d = r_ccwout_d;
    w_n_pein_v   = r_pein_v;
    w_n_pein_d   = r_pein_d;
    w_n_peout_v  = r_peout_v;
    w_n_peout_d  = r_peout_d;
    for (int n = 0; n < c_NODES; n++) begin
      // External phase: VC r_pol output slots cross the link into empty input slots.
      if (r_cwout_v[n][r_pol] && !r_cwin_v[(n + 1) % c_NODES][r_pol]) begin
        w_n_cwout_v[n][r_pol]                   = 1'b0;
        w_n_cwin_v[(n + 1) % c_NODES][r_pol]    = 1'b1;
        w_n_cwin_d[(n + 1) % c_NODES][r_pol]    = r_cwout_d[n][r_pol];
      end
      if (r_ccwout_v[n][r_pol] && !r_ccwin_v[(n + 3) % c_NODES][r_pol]) begin
        w_n_ccwout_v[n][r_pol]                  = 1'b0;
        w_n_ccwin_v[(n + 3) % c_NODES][r_pol]   = 1'b1;
        w_n_ccwin_d[(n + 3) % c_NODES][r_pol]   = r_ccwout_d[n][r_pol];
      end
      if (r_peout_v[n] && w_pero[n]) w_n_peout_v[n] = 1'b0;
      // Internal phase: VC w_q input slots and pe_in move to their targets.
      if (w_gnt[n][0]) w_n_cwin_v[n][w_q]  = 1'b0;
      if (w_gnt[n][1]) w_n_ccwin_v[n][w_q] = 1'b0;
      if (w_gnt[n][2]) w_n_pein_v[n]       = 1'b0;
      for (int s = 0; s < 3; s++) begin
        if (w_gnt[n][s]) begin
          case (w_tgt[n][s])
            c_TGT_PE: begin
              w_n_peout_v[n] = 1'b1;
              w_n_peout_d[n] = w_src_d[n][s];
            end
            c_TGT_CW: begin
              w_n_cwout_v[n][w_q] = 1'b1;
              w_n_cwout_d[n][w_q] = f_link(w_src_d[n][s], w_q);
            end
            default: begin
              w_n_ccwout_v[n][w_q] = 1'b1;
              w_n_ccwout_d[n][w_q] = f_link(w_src_d[n][s], w_q);
            end
          endcase
        end
      end
      if (w_pesi[n] && !r_pein_v[n]) begin
        w_n_pein_v[n] = 1'b1;
        w_n_pein_d[n] = w_pedi[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pol <= 1'b0;
      for (int n = 0; n < c_NODES; n++) begin
        r_cwin_v[n]   <= 2'b00;
        r_ccwin_v[n]  <= 2'b00;
        r_cwout_v[n]  <= 2'b00;
        r_ccwout_v[n] <= 2'b00;
        r_pein_v[n]   <= 1'b0;
        r_peout_v[n]  <= 1'b0;
        r_peout_d[n]  <= 64'h0;
      end
    end else begin
      r_pol      <= ~r_pol;
      r_cwin_v   <= w_n_cwin_v;
      r_ccwin_v  <= w_n_ccwin_v;
      r_cwout_v  <= w_n_cwout_v;
      r_ccwout_v <= w_n_ccwout_v;
      r_cwin_d   <= w_n_cwin_d;
      r_ccwin_d  <= w_n_ccwin_d;
      r_cwout_d  <= w_n_cwout_d;
      r_ccwout_d <= w_n_ccwout_d;
      r_pein_v   <= w_n_pein_v;
      r_pein_d   <= w_n_pein_d;
      r_peout_v  <= w_n_peout_v;
      r_peout_d  <= w_n_peout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gold_ring_noc.sv
`default_nettype none
// ============================================================================
// Module   : tb_gold_ring_noc
// Brief    : Scoreboard bench for gold_ring_noc with a destination-level model.
// Revision : 1.0
// ============================================================================
module tb_gold_ring_noc;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        pesi [4];
  logic        peri [4];
  logic [63:0] pedi [4];
  logic        peso [4];
  logic        pero [4];
  logic [63:0] pedo [4];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          in_flight = 0;
  int          pero_mode [4];
  logic [62:0] exp_q [4][$];
  logic        hold_v [4];
  logic [63:0] hold_d [4];

  always #5 clk = ~clk;

  gold_ring_noc dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pesi_node0(pesi[0]), .peri_node0(peri[0]), .pedi_node0(pedi[0]),
    .peso_node0(peso[0]), .pero_node0(pero[0]), .pedo_node0(pedo[0]),
    .pesi_node1(pesi[1]), .peri_node1(peri[1]), .pedi_node1(pedi[1]),
    .peso_node1(peso[1]), .pero_node1(pero[1]), .pedo_node1(pedo[1]),
    .pesi_node2(pesi[2]), .peri_node2(peri[2]), .pedi_node2(pedi[2]),
    .peso_node2(peso[2]), .pero_node2(pero[2]), .pedo_node2(pedo[2]),
    .pesi_node3(pesi[3]), .peri_node3(peri[3]), .pedi_node3(pedi[3]),
    .peso_node3(peso[3]), .pero_node3(pero[3]), .pedo_node3(pedo[3])
  );

  // Reference model: destination and delivered image from the routing rules.
  function automatic int model_dst(input int src, input logic [63:0] pkt);
    int hops;
    hops = $countones(pkt[55:48]);
    return pkt[62] ? (src - hops + 4) % 4 : (src + hops) % 4;
  endfunction

  function automatic logic [62:0] model_out(input logic [63:0] pkt);
    return {pkt[62:56], 8'h00, pkt[47:0]};
  endfunction

  function automatic logic [63:0] mk_pkt(input logic dir, input logic [7:0] hop,
                                         input logic [15:0] src, input logic [31:0] pay);
    return {1'b0, dir, 6'h00, hop, src, pay};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives PE backpressure away from the clock edge: 0 = ready, 1 = stalled, 2 = random.
  initial for (int n = 0; n < 4; n++) begin
    pero[n] = 1'b1;
    pero_mode[n] = 0;
    pesi[n] = 1'b0;
    pedi[n] = 64'h0;
    hold_v[n] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 4; n++)
      pero[n] = (pero_mode[n] == 0) ? 1'b1 :
                (pero_mode[n] == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  // Monitor: pops expected packets on each PE handshake and checks stalls hold steady.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int n = 0; n < 4; n++) begin
        if (hold_v[n]) begin
          n_tests++;
          if (peso[n] !== 1'b1 || pedo[n] !== hold_d[n]) begin
            n_fail++;
            $display("FAIL hold node%0d: peso=%0b pedo=%h required peso=1 pedo=%h",
                     n, peso[n], pedo[n], hold_d[n]);
          end
        end
        if (peso[n] === 1'b1 && pero[n] === 1'b1) begin
          bit found;
          found = 1'b0;
          for (int i = 0; i < exp_q[n].size(); i++) begin
            if (!found && exp_q[n][i] === pedo[n][62:0]) begin
              exp_q[n].delete(i);
              found = 1'b1;
            end
          end
          n_tests++;
          if (!found) begin
            n_fail++;
            $display("FAIL deliver node%0d: got %h, required one of %0d pending packets",
                     n, pedo[n], exp_q[n].size());
          end else begin
            in_flight--;
          end
        end
        hold_v[n] = (peso[n] === 1'b1) && (pero[n] === 1'b0);
        hold_d[n] = pedo[n];
      end
    end else begin
      for (int n = 0; n < 4; n++) hold_v[n] = 1'b0;
    end
  end

  task automatic inject(input int n, input logic [63:0] pkt);
    int g;
    g = 0;
    @(negedge clk);
    while (peri[n] !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (peri[n] !== 1'b1) begin
      n_fail++;
      $display("FAIL inject node%0d: peri=%0b required 1 within budget", n, peri[n]);
    end else begin
      pesi[n] = 1'b1;
      pedi[n] = pkt;
      @(posedge clk);
      exp_q[model_dst(n, pkt)].push_back(model_out(pkt));
      in_flight++;
      #1 pesi[n] = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (in_flight != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({name, " in_flight"}, 64'(in_flight), 64'd0);
    for (int n = 0; n < 4; n++)
      chk($sformatf("%s pending node%0d", name, n), 64'(exp_q[n].size()), 64'd0);
  endtask

  function automatic logic [7:0] rand_hop();
    case ($urandom_range(0, 3))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h03;
      default: return 8'h07;
    endcase
  endfunction

  task automatic random_node(input int n);
    int g;
    logic [63:0] pkt;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      g = 0;
      while (in_flight >= 3 && g < 500) begin
        @(negedge clk);
        g++;
      end
      pkt = {1'($urandom), 1'($urandom), 6'($urandom), rand_hop(), 16'(n), 32'($urandom)};
      inject(n, pkt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset polarity", 64'(polarity), 64'd0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("reset peri node%0d", n), 64'(peri[n]), 64'd1);
      chk($sformatf("reset peso node%0d", n), 64'(peso[n]), 64'd0);
      chk($sformatf("reset pedo node%0d", n), pedo[n], 64'd0);
    end
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("polarity edge%0d", k), 64'(polarity), 64'(k % 2));
    end

    // Single hop ccw, node1 -> node0, latency E0+3.
    inject(1, mk_pkt(1'b1, 8'h01, 16'd1, 32'd1));
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("lat1 peso0 k%0d", k), 64'(peso[0]), 64'(k == 3));
      for (int n = 1; n < 4; n++)
        chk($sformatf("lat1 peso%0d k%0d", n, k), 64'(peso[n]), 64'd0);
    end
    drain("one-hop", 50);

    // Two hops cw, node2 -> node0, latency E0+5.
    inject(2, mk_pkt(1'b0, 8'h03, 16'd2, 32'h0000_00a5));
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("lat2 peso0 k%0d", k), 64'(peso[0]), 64'(k == 5));
      chk($sformatf("lat2 peso3 k%0d", k), 64'(peso[3]), 64'd0);
    end
    drain("two-hop", 50);

    // ccw wrap 0 -> 3 and a hop-0 loopback.
    inject(0, mk_pkt(1'b1, 8'h01, 16'd0, 32'd3));
    inject(2, mk_pkt(1'b0, 8'h00, 16'd2, 32'h1234_5678));
    drain("wrap", 50);

    // Gather to node0 under backpressure, then release.
    pero_mode[0] = 1;
    @(posedge clk);
    inject(1, mk_pkt(1'b1, 8'h01, 16'd1, 32'h11));
    inject(2, mk_pkt(1'b0, 8'h03, 16'd2, 32'h22));
    inject(3, mk_pkt(1'b0, 8'h01, 16'd3, 32'h33));
    repeat (20) @(negedge clk);
    chk("gather stalled peso0", 64'(peso[0]), 64'd1);
    chk("gather stalled pending", 64'(exp_q[0].size()), 64'd3);
    pero_mode[0] = 0;
    drain("gather", 100);

    // Randomized concurrent traffic with random PE backpressure.
    for (int n = 0; n < 4; n++) pero_mode[n] = 2;
    fork
      random_node(0);
      random_node(1);
      random_node(2);
      random_node(3);
    join
    drain("random", 3000);
    for (int n = 0; n < 4; n++) pero_mode[n] = 0;

    // Mid-flight reset discards the packet.
    inject(1, mk_pkt(1'b0, 8'h03, 16'd1, 32'hdead));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) exp_q[n].delete();
    in_flight = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (12) @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("post-reset peri node%0d", n), 64'(peri[n]), 64'd1);
      chk($sformatf("post-reset peso node%0d", n), 64'(peso[n]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gold_ring_noc.md
# gold_ring_noc

Four-node bidirectional ring network-on-chip used as the interconnect for the CMP processing elements (PEs). Each node contains a router with clockwise (cw) and counter-clockwise (ccw) ring links and one local PE port. Routing is source-routed by a direction bit and a hop count carried in each 64-bit packet. Even/odd virtual channels (VC0/VC1) alternate every cycle under a global polarity signal.

## Interface
- No parameters. The packet width is fixed at 64.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- polarity  out  1  global VC phase. It is 0 in reset and toggles every cycle after reset.
- pesi_nodeN  in  1  (N=0..3) PE send: a packet is offered on pedi_nodeN.
- peri_nodeN  out  1  router ready to accept a PE packet (PE input buffer empty).
- pedi_nodeN  in  64  PE packet in.
- peso_nodeN  out  1  router is presenting a packet on pedo_nodeN.
- pero_nodeN  in  1  PE ready to take the output packet.
- pedo_nodeN  out  64  packet out to the PE.

## Operation
- Packet fields:
  - [63] vc
  - [62] dir (0 = cw, node i→i+1 mod 4; 1 = ccw, node i→i-1 mod 4)
  - [61:56] reserved, passed through unchanged
  - [55:48] hop, thermometer code: 8'h01 = 1 hop, 8'h03 = 2 hops
  - [47:32] source id, passed through
  - [31:0] payload, passed through
- Each router has the following storage:
  - cw_in and ccw_in input buffers: one 1-entry slot per VC.
  - cw_out and ccw_out output buffers: one 1-entry slot per VC.
  - pe_in: a single 1-entry buffer.
  - pe_out: a single 1-entry buffer.
- Let p be the current polarity.
- External phase (every cycle):
  - Output slot VC p of cw_out/ccw_out transfers to the downstream router's cw_in/ccw_in slot VC p, but only if that slot is empty.
  - Otherwise the packet holds in place.
- Internal phase (every cycle): input slots of VC (1-p) and pe_in are routed as follows.
  - hop == 0 → pe_out.
  - hop != 0, dir=0 → cw_out slot VC (1-p); dir=1 → ccw_out slot VC (1-p).
  - On entering a link output buffer, hop is shifted right by 1 and bit63 is overwritten with the slot VC.
  - A move happens only if the target slot is empty, or is pe_out being drained in the same cycle. Otherwise the source holds.
- Arbitration per target, fixed priority: cw_in > ccw_in > pe_in.
- The vc bit of an injected packet is ignored.
- A PE packet with hop 0 loops back to its own pe_out.
- PE input: when pesi=1 and peri=1 at a clock edge, pedi is captured into pe_in. When peri=0, pesi is ignored.
- PE output:
  - peso = pe_out full; pedo = pe_out contents.
  - The entry is removed at an edge where pero=1.
  - When pe_out is empty, pedo holds its last value.
- No packet is ever dropped or duplicated.

## Timing
- Reset (reset=0 at an edge) forces: polarity=0, all buffers empty, peso=0, pedo=0, peri=1.
- A reset asserted mid-operation discards all in-flight packets.
- Zero-load latency, counting injection acceptance as edge E0:
  - E1: pe_in → link output.
  - E2: link transfer.
  - E3: eject to pe_out.
  - Each extra hop adds 2 edges.
  - peso=1 in the cycle after edge E0+2h+1 (h = hop count ≥ 1).
- peri drops the cycle after acceptance and returns to 1 the cycle after pe_in empties. The sustained PE injection rate is 1 packet per 2 cycles.
- Backpressure: a full pe_out with pero=0 stalls ejection. This blocks the matching input slots and, transitively, the upstream links.

## Test plan
- Reset: hold reset=0 for 3 cycles → polarity=0, all peri=1, peso=0, pedo=0. After release, polarity alternates 0,1,0,…
- Node1 injects dir=1, hop=8'h01, source=1, payload=1 → node0 peso=1 exactly once, 4 cycles after acceptance, with pedo[55:48]=0, [47:32]=1, [31:0]=1. No other node asserts peso.
- Node2 injects dir=0, hop=8'h03 → delivered only at node0 at E0+5. Node3 does not assert peso.
- Node0 injects dir=1, hop=8'h01, payload=3 → delivered at node3 (ccw wrap 0→3).
- Gather to node0: node1 (dir1, hop 01), node2 (dir0, hop 03) and node3 (dir0, hop 01) inject in consecutive cycles → node0 receives exactly three packets, sources 1, 2 and 3.
- Backpressure: pero_node0=0 during the gather above → peso_node0 stays 1 with a stable pedo. After pero_node0=1, all three packets arrive and none is lost.
